// File: rtl/acq_readout_sequencer_pkg.sv
// Shared types and helpers for the acquisition readout sequencer.
package acq_readout_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAITRDY,
        S_READ,
        S_DRAIN,
        S_FINISH
    } seq_state_t;

    localparam int unsigned NCH_DEFAULT    = 4;
    localparam int unsigned RD_LAT_DEFAULT = 2;
    localparam int unsigned MAX_CH         = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } ch_sel_t;

    // Lowest set mask bit at or above 'from'; found=0 when none remain.
    function automatic ch_sel_t next_set_ch(input logic [MAX_CH-1:0] mask,
                                            input int unsigned       from);
        ch_sel_t sel;
        sel = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (!sel.found && (i >= from) && mask[i]) begin
                sel.found = 1'b1;
                sel.idx   = 5'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/acq_readout_sequencer_seq_skid_fifo.sv
// Byte FIFO absorbing RAM reads still in flight when the host link stalls.
module seq_skid_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [7:0]                   push_data_i,
    input  logic                         pop_i,
    output logic [7:0]                   head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CW'(1);
            end else if (!push_i && pop_i) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/acq_readout_sequencer.sv
// Arms one capture, then streams per-channel sample RAM contents as bytes.
module acq_readout_sequencer
    import acq_readout_sequencer_pkg::*;
#(
    parameter int unsigned RAM_WIDTH = 10,
    parameter int unsigned NCH       = NCH_DEFAULT,
    parameter int unsigned RD_LAT    = RD_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [NCH-1:0]       chmask,
    input  logic [RAM_WIDTH-1:0] nsmp_req,
    output logic                 start_trigger,
    input  logic                 data_ready,
    input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
    input  logic [RAM_WIDTH-1:0] triggerpoint,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    input  logic [8*NCH-1:0]     ram_q,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned DEPTH = RD_LAT + 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1;

    seq_state_t           state_q, state_d;
    logic [NCH-1:0]       mask_q, mask_d;
    logic [RAM_WIDTH-1:0] nsmp_q, nsmp_d;
    logic [RAM_WIDTH-1:0] base_q, base_d;
    logic [RAM_WIDTH-1:0] idx_q, idx_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic                 start_q, start_d;
    logic [CW-1:0]        infl_q, infl_d;
    logic [RD_LAT-1:0]    vld_pipe_q;
    logic [CHW-1:0]       ch_pipe_q [RD_LAT];

    logic                 issue, flush, credit_ok, push, pop;
    logic [7:0]           push_data;
    logic [CW-1:0]        fifo_cnt;
    ch_sel_t              sel;

    // Credits count FIFO slots plus reads in flight, all from registers, so
    // tx_ready never reaches rden combinationally.
    assign credit_ok = (32'(fifo_cnt) + 32'(infl_q)) < DEPTH;
    assign push      = vld_pipe_q[RD_LAT-1];
    assign push_data = ram_q[32'(ch_pipe_q[RD_LAT-1]) * 8 +: 8];
    assign pop       = tx_valid && tx_ready;

    // Next-state, read issue and in-flight accounting.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        nsmp_d  = nsmp_q;
        base_d  = base_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        start_d = 1'b0;
        issue   = 1'b0;
        flush   = 1'b0;
        sel     = '0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    mask_d  = chmask;
                    nsmp_d  = nsmp_req;
                    start_d = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!data_ready) state_d = S_WAITRDY;
            end
            S_WAITRDY: begin
                if (data_ready) begin
                    base_d = wraddress_triggerpoint - triggerpoint;
                    idx_d  = '0;
                    sel    = next_set_ch(MAX_CH'(mask_q), 0);
                    if (!sel.found || (nsmp_q == '0)) begin
                        state_d = S_FINISH;
                    end else begin
                        ch_d    = CHW'(sel.idx);
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (idx_q == nsmp_q - RAM_WIDTH'(1)) begin
                        idx_d = '0;
                        sel   = next_set_ch(MAX_CH'(mask_q), 32'(ch_q) + 32'd1);
                        if (sel.found) ch_d = CHW'(sel.idx);
                        else           state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + RAM_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if ((infl_q == '0) && (fifo_cnt == '0)) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end
        infl_d = infl_q;
        if (flush)               infl_d = '0;
        else if (issue && !push) infl_d = infl_q + CW'(1);
        else if (!issue && push) infl_d = infl_q - CW'(1);
    end

    // Control and run-parameter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            nsmp_q  <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            start_q <= 1'b0;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            nsmp_q  <= nsmp_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            start_q <= start_d;
            infl_q  <= infl_d;
        end
    end

    // Delay line matching RAM latency, carrying valid and channel per read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                ch_pipe_q[i] <= '0;
            end
        end else if (flush) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= issue;
            ch_pipe_q[0]  <= ch_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                ch_pipe_q[i]  <= ch_pipe_q[i-1];
            end
        end
    end

    seq_skid_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (tx_data),
        .count_o     (fifo_cnt)
    );

    assign start_trigger = start_q;
    assign rden          = issue;
    assign rdaddress     = base_q + idx_q;
    assign tx_valid      = (fifo_cnt != '0);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FINISH);

endmodule

// File: tb/tb_acq_readout_sequencer.sv
// Directed bench for the acquisition readout sequencer.
module tb_acq_readout_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       arm;
    logic       abort;
    logic [3:0] chmask;
    logic [9:0] nsmp_req;
    logic       start_trigger;
    logic       data_ready;
    logic [9:0] wtp;
    logic [9:0] tp;
    logic       rden;
    logic [9:0] rdaddress;
    logic [31:0] ram_q = '0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int n_start = 0, n_done = 0, n_valid = 0, n_unstable = 0, done_cyc = 0;
    logic [7:0] bytes_q[$];
    int         byte_cyc[$];
    logic [9:0] addr_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    int         rdy_mode   = 0;
    logic [9:0] ram_a1     = '0;

    acq_readout_sequencer #(
        .RAM_WIDTH(10),
        .NCH(4),
        .RD_LAT(2)
    ) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .arm                    (arm),
        .abort                  (abort),
        .chmask                 (chmask),
        .nsmp_req               (nsmp_req),
        .start_trigger          (start_trigger),
        .data_ready             (data_ready),
        .wraddress_triggerpoint (wtp),
        .triggerpoint           (tp),
        .rden                   (rden),
        .rdaddress              (rdaddress),
        .ram_q                  (ram_q),
        .tx_data                (tx_data),
        .tx_valid               (tx_valid),
        .tx_ready               (tx_ready),
        .busy                   (busy),
        .done                   (done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] smp(input int c, input int a);
        return 8'(a * 5 + c * 37 + a / 256);
    endfunction

    // Sample RAM with two-cycle read latency.
    always @(posedge clk) begin
        ram_a1 <= rdaddress;
        ram_q  <= {smp(3, int'(ram_a1)), smp(2, int'(ram_a1)),
                   smp(1, int'(ram_a1)), smp(0, int'(ram_a1))};
        cyc    <= cyc + 1;
    end

    // Observe the interfaces away from the active edge.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            bytes_q.push_back(tx_data);
            byte_cyc.push_back(cyc);
        end
        if (rden) addr_q.push_back(rdaddress);
        if (tx_valid) n_valid++;
        if (start_trigger) n_start++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) n_unstable++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 9) < 3);
                default: tx_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input logic [3:0] m, input logic [9:0] n,
                             input logic [9:0] w, input logic [9:0] t, input logic ab);
        chmask = m; nsmp_req = n; wtp = w; tp = t; arm = 1'b1; abort = ab;
        tick();
        arm = 1'b0; abort = 1'b0;
        repeat (3) tick();
        data_ready = 1'b0;
        repeat (4) tick();
        data_ready = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (start_trigger !== 1'b0) $display("FAIL reset_start got=%b exp=0", start_trigger); else n_pass++;
        n_checks++; if (rden !== 1'b0) $display("FAIL reset_rden got=%b exp=0", rden); else n_pass++;
        n_checks++; if (rdaddress !== 10'd0) $display("FAIL reset_rdaddress got=%0d exp=0", rdaddress); else n_pass++;
        n_checks++; if (tx_data !== 8'd0) $display("FAIL reset_tx_data got=%0h exp=0", tx_data); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    endtask

    task automatic test_basic();
        int b0, a0, s0, d0;
        bit ok;
        logic [7:0] eb;
        b0 = bytes_q.size(); a0 = addr_q.size(); s0 = n_start; d0 = n_done;
        rdy_mode = 0;
        start_run(4'b0101, 10'd4, 10'd600, 10'd100, 1'b0);
        wait_done(300, ok);
        tick();
        n_checks++; if (!ok) $display("FAIL basic_done got=0 exp=1"); else n_pass++;
        n_checks++; if (n_start - s0 !== 1) $display("FAIL basic_start_pulses got=%0d exp=1", n_start - s0); else n_pass++;
        n_checks++; if (n_done - d0 !== 1) $display("FAIL basic_done_pulses got=%0d exp=1", n_done - d0); else n_pass++;
        n_checks++; if (addr_q.size() - a0 !== 8) $display("FAIL basic_nreads got=%0d exp=8", addr_q.size() - a0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a0 + i >= addr_q.size()) $display("FAIL basic_addr%0d got=none exp=%0d", i, 500 + i % 4);
            else if (addr_q[a0 + i] !== 10'(500 + i % 4)) $display("FAIL basic_addr%0d got=%0d exp=%0d", i, addr_q[a0 + i], 500 + i % 4);
            else n_pass++;
        end
        n_checks++; if (bytes_q.size() - b0 !== 8) $display("FAIL basic_nbytes got=%0d exp=8", bytes_q.size() - b0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            eb = smp((i < 4) ? 0 : 2, 500 + i % 4);
            n_checks++;
            if (b0 + i >= bytes_q.size()) $display("FAIL basic_byte%0d got=none exp=%0h", i, eb);
            else if (bytes_q[b0 + i] !== eb) $display("FAIL basic_byte%0d got=%0h exp=%0h", i, bytes_q[b0 + i], eb);
            else n_pass++;
        end
        if (bytes_q.size() >= b0 + 8) begin
            n_checks++;
            if (byte_cyc[b0 + 7] - byte_cyc[b0] !== 7) $display("FAIL basic_throughput got=%0d exp=7", byte_cyc[b0 + 7] - byte_cyc[b0]);
            else n_pass++;
            n_checks++;
            if (!(done_cyc > byte_cyc[b0 + 7])) $display("FAIL basic_done_after_last got=%0d exp=>%0d", done_cyc, byte_cyc[b0 + 7]);
            else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_wrap();
        int b0, a0;
        bit ok;
        logic [9:0] ea [4];
        ea[0] = 10'd1022; ea[1] = 10'd1023; ea[2] = 10'd0; ea[3] = 10'd1;
        b0 = bytes_q.size(); a0 = addr_q.size();
        rdy_mode = 0;
        start_run(4'b0001, 10'd4, 10'd3, 10'd5, 1'b0);
        wait_done(300, ok);
        tick();
        n_checks++; if (!ok) $display("FAIL wrap_done got=0 exp=1"); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (a0 + i >= addr_q.size()) $display("FAIL wrap_addr%0d got=none exp=%0d", i, ea[i]);
            else if (addr_q[a0 + i] !== ea[i]) $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, addr_q[a0 + i], ea[i]);
            else n_pass++;
            n_checks++;
            if (b0 + i >= bytes_q.size()) $display("FAIL wrap_byte%0d got=none exp=%0h", i, smp(0, int'(ea[i])));
            else if (bytes_q[b0 + i] !== smp(0, int'(ea[i]))) $display("FAIL wrap_byte%0d got=%0h exp=%0h", i, bytes_q[b0 + i], smp(0, int'(ea[i])));
            else n_pass++;
        end
        n_checks++; if (bytes_q.size() - b0 !== 4) $display("FAIL wrap_nbytes got=%0d exp=4", bytes_q.size() - b0); else n_pass++;
    endtask

    task automatic test_empty_mask();
        int s0, d0, v0, a0;
        bit ok;
        s0 = n_start; d0 = n_done; v0 = n_valid; a0 = addr_q.size();
        rdy_mode = 0;
        chmask = 4'b0000; nsmp_req = 10'd8; wtp = 10'd50; tp = 10'd10; arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (3) tick();
        data_ready = 1'b0;
        repeat (10) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL empty_waiting_busy got=%b exp=1", busy); else n_pass++;
        n_checks++; if (n_done - d0 !== 0) $display("FAIL empty_early_done got=%0d exp=0", n_done - d0); else n_pass++;
        data_ready = 1'b1;
        wait_done(50, ok);
        tick();
        n_checks++; if (!ok) $display("FAIL empty_done got=0 exp=1"); else n_pass++;
        n_checks++; if (n_start - s0 !== 1) $display("FAIL empty_start_pulses got=%0d exp=1", n_start - s0); else n_pass++;
        n_checks++; if (n_valid - v0 !== 0) $display("FAIL empty_valid_cycles got=%0d exp=0", n_valid - v0); else n_pass++;
        n_checks++; if (addr_q.size() - a0 !== 0) $display("FAIL empty_reads got=%0d exp=0", addr_q.size() - a0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int b0, a0, s0, d0, u0, mism;
        bit ok;
        b0 = bytes_q.size(); a0 = addr_q.size(); s0 = n_start; d0 = n_done; u0 = n_unstable;
        rdy_mode = 1;
        start_run(4'b1111, 10'd64, 10'd200, 10'd50, 1'b0);
        repeat (30) tick();
        chmask = 4'b0001; nsmp_req = 10'd2; arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_done(6000, ok);
        rdy_mode = 0;
        tick();
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (b0 + i >= bytes_q.size()) mism++;
            else if (bytes_q[b0 + i] !== smp(i / 64, 150 + i % 64)) mism++;
        end
        n_checks++; if (!ok) $display("FAIL bp_done got=0 exp=1"); else n_pass++;
        n_checks++; if (bytes_q.size() - b0 !== 256) $display("FAIL bp_nbytes got=%0d exp=256", bytes_q.size() - b0); else n_pass++;
        n_checks++; if (mism !== 0) $display("FAIL bp_order got=%0d_bad exp=0_bad", mism); else n_pass++;
        n_checks++; if (n_unstable - u0 !== 0) $display("FAIL bp_stall_stable got=%0d exp=0", n_unstable - u0); else n_pass++;
        n_checks++; if (addr_q.size() - a0 !== 256) $display("FAIL bp_nreads got=%0d exp=256", addr_q.size() - a0); else n_pass++;
        n_checks++; if (n_start - s0 !== 1) $display("FAIL bp_arm_ignored got=%0d exp=1", n_start - s0); else n_pass++;
        n_checks++; if (n_done - d0 !== 1) $display("FAIL bp_done_pulses got=%0d exp=1", n_done - d0); else n_pass++;
    endtask

    task automatic test_abort();
        int b0, d0, s0, mism;
        bit found, ok;
        b0 = bytes_q.size();
        rdy_mode = 0;
        start_run(4'b1111, 10'd64, 10'd200, 10'd50, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bytes_q.size() - b0 >= 10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        d0 = n_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (!found) $display("FAIL abort_reach10 got=%0d exp=10", bytes_q.size() - b0); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL abort_tx_valid got=%b exp=0", tx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (rden !== 1'b0) $display("FAIL abort_rden got=%b exp=0", rden); else n_pass++;
        repeat (20) tick();
        mism = 0;
        for (int i = 0; i < 10; i++) begin
            if (b0 + i >= bytes_q.size()) mism++;
            else if (bytes_q[b0 + i] !== smp(0, 150 + i)) mism++;
        end
        n_checks++; if (n_done - d0 !== 0) $display("FAIL abort_no_done got=%0d exp=0", n_done - d0); else n_pass++;
        n_checks++; if (bytes_q.size() - b0 !== 10) $display("FAIL abort_nbytes got=%0d exp=10", bytes_q.size() - b0); else n_pass++;
        n_checks++; if (mism !== 0) $display("FAIL abort_bytes got=%0d_bad exp=0_bad", mism); else n_pass++;
        // Clean follow-up run, arm presented together with abort while idle.
        b0 = bytes_q.size(); s0 = n_start;
        start_run(4'b1010, 10'd5, 10'd700, 10'd200, 1'b1);
        wait_done(300, ok);
        tick();
        mism = 0;
        for (int i = 0; i < 10; i++) begin
            if (b0 + i >= bytes_q.size()) mism++;
            else if (bytes_q[b0 + i] !== smp((i < 5) ? 1 : 3, 500 + i % 5)) mism++;
        end
        n_checks++; if (!ok) $display("FAIL rerun_done got=0 exp=1"); else n_pass++;
        n_checks++; if (n_start - s0 !== 1) $display("FAIL rerun_arm_wins got=%0d exp=1", n_start - s0); else n_pass++;
        n_checks++; if (bytes_q.size() - b0 !== 10) $display("FAIL rerun_nbytes got=%0d exp=10", bytes_q.size() - b0); else n_pass++;
        n_checks++; if (mism !== 0) $display("FAIL rerun_bytes got=%0d_bad exp=0_bad", mism); else n_pass++;
    endtask

    task automatic test_async_reset();
        rdy_mode = 2;
        start_run(4'b1111, 10'd16, 10'd100, 10'd0, 1'b0);
        repeat (10) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL areset_pre_busy got=%b exp=1", busy); else n_pass++;
        n_checks++; if (tx_valid !== 1'b1) $display("FAIL areset_pre_valid got=%b exp=1", tx_valid); else n_pass++;
        #1;
        rstn = 1'b0;
        #1;
        n_checks++; if (start_trigger !== 1'b0) $display("FAIL areset_start got=%b exp=0", start_trigger); else n_pass++;
        n_checks++; if (rden !== 1'b0) $display("FAIL areset_rden got=%b exp=0", rden); else n_pass++;
        n_checks++; if (rdaddress !== 10'd0) $display("FAIL areset_rdaddress got=%0d exp=0", rdaddress); else n_pass++;
        n_checks++; if (tx_data !== 8'd0) $display("FAIL areset_tx_data got=%0h exp=0", tx_data); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL areset_tx_valid got=%b exp=0", tx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL areset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL areset_done got=%b exp=0", done); else n_pass++;
        repeat (2) tick();
        rstn = 1'b1;
        rdy_mode = 0;
        tick();
    endtask

    initial begin
        rstn = 1'b0; arm = 1'b0; abort = 1'b0; chmask = '0; nsmp_req = '0;
        data_ready = 1'b1; wtp = '0; tp = '0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_wrap();
        test_empty_mask();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
